// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and bundle types shared by the fetch stage.
// Holds the NOP encoding, default reset PC and instruction field positions.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int F3_LSB  = 12;
    localparam int F3_MSB  = 14;
    localparam int F7_BIT  = 30;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO, power-of-two depth, with flush.
// Ports: push/wdata in, pop in, flush in, rdata (head), count, full, empty.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: keeps the fetch PC, issues word reads to imem, buffers
// {pc,instr} and hands them to decode under valid/ready.
// Ports: imem_req_*/imem_addr out, imem_rsp_*/imem_rdata in,
// instr_valid/instr_ready handshake, Instr/PC/PCPlus4 and decoded
// fields out, PCSrc/PCTarget redirect in.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [6:0]  Opcode,
    output logic [2:0]  funct3,
    output logic        funct7
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] out_nxt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] buf_cnt;
    logic [CW-1:0] rq_cnt;
    logic [CW:0]   credit;
    logic          acc;
    logic          rsp;
    logic          hs;
    logic          redir;
    logic          keep;
    logic          buf_full;
    logic          buf_empty;
    logic          rq_full;
    logic          rq_empty;
    logic [31:0]   rq_pc;
    fetch_entry_t  wentry;
    fetch_entry_t  head;
    logic          unused;

    // Credits: in-flight plus buffered never exceeds the buffer depth.
    assign credit = {1'b0, out_cnt} + {1'b0, buf_cnt};
    assign imem_req_valid = !rst && (credit < (CW+1)'(FIFO_DEPTH));
    assign imem_addr = fetch_pc;

    assign acc   = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a leftover from before reset.
    assign rsp   = imem_rsp_valid && (out_cnt != '0);
    assign hs    = instr_valid && instr_ready;
    assign redir = hs && PCSrc;
    assign keep  = rsp && (drop_cnt == '0) && !redir;

    assign out_nxt = out_cnt + CW'(acc) - CW'(rsp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            out_cnt <= out_nxt;
            if (redir) begin
                fetch_pc <= {PCTarget[31:2], 2'b00};
                // Everything still in flight is now wrong-path.
                drop_cnt <= out_nxt;
            end else begin
                if (acc) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH(32),
        .DEPTH(FIFO_DEPTH)
    ) u_rq (
        .clk  (clk),
        .rst  (rst),
        .push (acc),
        .wdata(fetch_pc),
        .pop  (rsp),
        .flush(1'b0),
        .rdata(rq_pc),
        .count(rq_cnt),
        .full (rq_full),
        .empty(rq_empty)
    );

    assign wentry = '{pc: rq_pc, instr: imem_rdata};

    fetch_fifo #(
        .WIDTH($bits(fetch_entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_buf (
        .clk  (clk),
        .rst  (rst),
        .push (keep),
        .wdata(wentry),
        .pop  (hs),
        .flush(redir),
        .rdata(head),
        .count(buf_cnt),
        .full (buf_full),
        .empty(buf_empty)
    );

    assign instr_valid = !buf_empty;
    assign Instr   = instr_valid ? head.instr : NOP_INSTR;
    assign PC      = instr_valid ? head.pc : 32'd0;
    assign PCPlus4 = PC + 32'd4;
    assign Opcode  = Instr[OPC_MSB:OPC_LSB];
    assign funct3  = Instr[F3_MSB:F3_LSB];
    assign funct7  = Instr[F7_BIT];

    assign unused = ^{PCTarget[1:0], rq_cnt, rq_full, rq_empty, buf_full};

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a queue-based scoreboard.
// A memory model answers requests; a monitor checks every decode pop.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [6:0]  Opcode;
    logic [2:0]  funct3;
    logic        funct7;

    fetch_unit #(
        .RESET_PC  (32'h0000_0100),
        .FIFO_DEPTH(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .PCSrc         (PCSrc),
        .PCTarget      (PCTarget),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .Instr         (Instr),
        .PC            (PC),
        .PCPlus4       (PCPlus4),
        .Opcode        (Opcode),
        .funct3        (funct3),
        .funct7        (funct7)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    exp_t        exp_q[$];
    pend_t       pend[$];
    logic [31:0] acc_log[$];
    int cyc   = 0;
    int lat   = 1;
    int hs    = 0;
    int nchk  = 0;
    int nfail = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0A5C_3093;
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        nchk++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back('{pc, mem_word(pc)});
    endtask

    task automatic consume(input int n);
        int t0;
        t0 = hs + n;
        instr_ready = 1'b1;
        for (int i = 0; i < 200 && hs < t0; i++) step();
        instr_ready = 1'b0;
        if (hs < t0) begin
            nchk++;
            nfail++;
            $display("FAIL consume_timeout: got %0d want %0d", hs, t0);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        instr_ready = 1'b0;
        PCSrc = 1'b0;
        PCTarget = 32'd0;
        repeat (3) step();
        acc_log.delete();
        rst = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Request acceptance is observed mid-cycle, when inputs are stable.
    initial forever begin
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) begin
            pend.push_back('{imem_addr, cyc + lat});
            acc_log.push_back(imem_addr);
        end
    end

    // In-order memory: one response per cycle once its latency expires.
    initial begin
        pend_t p;
        imem_rsp_valid = 1'b0;
        imem_rdata = 32'd0;
        forever begin
            step();
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                p = pend.pop_front();
                imem_rdata = mem_word(p.addr);
                imem_rsp_valid = 1'b1;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rdata = 32'd0;
            end
        end
    end

    // Monitor: every decode handshake pops one expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (instr_valid && instr_ready) begin
                hs++;
                if (exp_q.size() == 0) begin
                    nchk++;
                    nfail++;
                    $display("FAIL extra_instr: got pc %h want none", PC);
                end else begin
                    e = exp_q.pop_front();
                    chk("pc", PC, e.pc);
                    chk("instr", Instr, e.instr);
                    chk("pcplus4", PCPlus4, e.pc + 32'd4);
                    chk("opcode", {25'd0, Opcode}, {25'd0, e.instr[6:0]});
                    chk("funct3", {29'd0, funct3}, {29'd0, e.instr[14:12]});
                    chk("funct7", {31'd0, funct7}, {31'd0, e.instr[30]});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int hs0;
        bit saw;
        rst = 1'b1;
        instr_ready = 1'b0;
        PCSrc = 1'b0;
        PCTarget = 32'd0;
        imem_req_ready = 1'b1;

        @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", Instr, NOP_INSTR);
        chk("rst_pc", PC, 0);
        chk("rst_pcplus4", PCPlus4, 32'd4);
        step();

        // Streaming: latency and one instruction per cycle.
        reset_dut();
        hs0 = hs;
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) push_exp(32'h100 + 32'(4 * i));
        @(negedge clk);
        chk("p1_req_valid", imem_req_valid, 1);
        chk("p1_addr0", imem_addr, 32'h100);
        chk("p1_valid0", instr_valid, 0);
        @(negedge clk);
        chk("p1_addr1", imem_addr, 32'h104);
        chk("p1_valid1", instr_valid, 0);
        @(negedge clk);
        chk("p1_addr2", imem_addr, 32'h108);
        chk("p1_valid2", instr_valid, 1);
        chk("p1_pc", PC, 32'h100);
        chk("p1_pcplus4", PCPlus4, 32'h104);
        repeat (6) step();
        chk("p1_throughput", hs - hs0, 6);
        instr_ready = 1'b0;
        chk("p1_left", exp_q.size(), 0);

        // Decode stall: credits cap outstanding + buffered at 4.
        reset_dut();
        repeat (10) step();
        chk("p2_reqs", acc_log.size(), 4);
        chk("p2_req_valid", imem_req_valid, 0);
        for (int i = 0; i < 4; i++)
            chk("p2_req_addr", acc_log[i], 32'h100 + 32'(4 * i));
        for (int i = 0; i < 5; i++) push_exp(32'h100 + 32'(4 * i));
        consume(5);
        chk("p2_left", exp_q.size(), 0);

        // Redirect on PC 0x108 while responses are in flight.
        reset_dut();
        push_exp(32'h100);
        push_exp(32'h104);
        consume(2);
        push_exp(32'h108);
        PCSrc = 1'b1;
        PCTarget = 32'h203;
        consume(1);
        PCSrc = 1'b0;
        chk("p3_req_valid", imem_req_valid, 1);
        chk("p3_target", imem_addr, 32'h200);
        push_exp(32'h200);
        push_exp(32'h204);
        consume(2);
        chk("p3_left", exp_q.size(), 0);

        // PCSrc without a handshake must not redirect.
        reset_dut();
        instr_ready = 1'b1;
        PCSrc = 1'b1;
        PCTarget = 32'h300;
        step();
        instr_ready = 1'b0;
        repeat (6) step();
        PCSrc = 1'b0;
        for (int i = 0; i < 5; i++) push_exp(32'h100 + 32'(4 * i));
        consume(5);
        chk("p4_left", exp_q.size(), 0);

        // Address wrap at the top of memory.
        reset_dut();
        push_exp(32'h100);
        PCSrc = 1'b1;
        PCTarget = 32'hFFFF_FFF8;
        consume(1);
        PCSrc = 1'b0;
        acc_log.delete();
        push_exp(32'hFFFF_FFF8);
        push_exp(32'hFFFF_FFFC);
        push_exp(32'h0000_0000);
        consume(3);
        chk("p5_req0", acc_log[0], 32'hFFFF_FFF8);
        chk("p5_req1", acc_log[1], 32'hFFFF_FFFC);
        chk("p5_req2", acc_log[2], 32'h0000_0000);
        chk("p5_left", exp_q.size(), 0);

        // Reset with two requests in flight; late responses ignored.
        lat = 6;
        reset_dut();
        step();
        step();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 30 && pend.size() > 0; i++) begin
            step();
            if (instr_valid) saw = 1'b1;
        end
        step();
        if (instr_valid) saw = 1'b1;
        chk("p6_late_pending", pend.size(), 0);
        chk("p6_no_valid", {31'd0, saw}, 0);
        chk("p6_req_valid", imem_req_valid, 1);
        chk("p6_addr", imem_addr, 32'h100);
        lat = 1;
        imem_req_ready = 1'b1;
        push_exp(32'h100);
        push_exp(32'h104);
        consume(2);
        chk("p6_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nchk, nfail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that feeds `Control_Unit` and the datapath. It keeps the fetch PC and issues word requests to instruction memory. Returned instructions are buffered with their PC in a small FIFO and presented to decode under a valid/ready handshake. `PCSrc`/`PCTarget` from the control unit and datapath are accepted as a redirect that flushes wrong-path work.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `FIFO_DEPTH`, 4: instruction buffer entries; power of two, ≥2; also caps in-flight requests.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `PCSrc` in 1: redirect request (Jump | Branch&zero); sampled only on a decode handshake.
- `PCTarget` in 32: redirect address; bits [1:0] ignored (forced 00).
- `imem_req_valid` out 1: request valid.
- `imem_req_ready` in 1: memory accepts request.
- `imem_addr` out 32: word-aligned request address.
- `imem_rsp_valid` in 1: response valid; in order, ≥1 cycle after acceptance, no backpressure.
- `imem_rdata` in 32: response instruction word.
- `instr_valid` out 1: head entry valid.
- `instr_ready` in 1: decode consumes head.
- `Instr` out 32: head instruction; 32'h0000_0013 (NOP) when `instr_valid`=0.
- `PC` out 32: head PC; 0 when empty.
- `PCPlus4` out 32: `PC`+4 mod 2^32.
- `Opcode` out 7, `funct3` out 3, `funct7` out 1: `Instr[6:0]`, `Instr[14:12]`, `Instr[30]`.

## Operation
- State: `fetch_pc` (32), `out_cnt` (outstanding requests), `drop_cnt` (stale responses to discard), FIFO of {pc, instr}, and a request-PC FIFO tracking in-flight addresses.
- Request: `imem_req_valid` = (`out_cnt` + FIFO count < `FIFO_DEPTH`), using registered values. `imem_addr` = `fetch_pc`. On valid&ready: `fetch_pc` += 4 (wraps 0xFFFF_FFFC → 0), `out_cnt`++.
- Response: `out_cnt`--. If `drop_cnt`>0, discard and `drop_cnt`--. Otherwise write {req pc, `imem_rdata`} into the FIFO. Credits guarantee the FIFO never overflows.
- Decode: a handshake (`instr_valid` & `instr_ready`) pops the head.
- Redirect: handshake & `PCSrc`. At the next edge:
  - FIFO flushed.
  - `fetch_pc` ← {`PCTarget`[31:2],2'b00}.
  - `drop_cnt` ← `out_cnt` after this cycle's request/response updates. A request accepted in the redirect cycle is dropped; a response arriving in the redirect cycle is discarded, not written.
- `PCSrc` without a handshake has no effect.
- A response with `out_cnt`=0 (e.g. after a mid-operation reset) is ignored.

## Timing
- Reset values:
  - `fetch_pc`=`RESET_PC`; all counters 0; FIFO empty.
  - `instr_valid`=0, `Instr`=NOP, `PC`=0, `PCPlus4`=4.
  - `imem_req_valid`=0 while `rst` is high.
- First request is issued in the first cycle after `rst` deasserts.
- Latency: request accepted at N, response at N+k, `instr_valid` at N+k+1 (registered FIFO write, no bypass).
- Throughput: with `FIFO_DEPTH`=4 and k=1, sustains 1 instruction/cycle while `instr_ready`=1.
- Redirect at cycle R: first target request at R+1; first target instruction valid no earlier than R+3 (k=1).
- FIFO full or credits exhausted: `imem_req_valid`=0; the bench checks no FIFO overflow.
- Outputs are driven from registers/FIFO head only. There is no combinational path from `PCSrc` to `imem_*` within a cycle.

## Structure
- Package `fetch_pkg` holds: `NOP_INSTR`=32'h0000_0013, `RESET_PC` default, and instruction field bit positions (opcode, funct3, funct7 bit).
- One sub-module, `fetch_fifo`: synchronous FIFO, parameterized width/depth, with push, pop, flush, count, full and empty. It is instantiated twice: the instruction buffer ({pc,instr}, 64b) and the in-flight request-PC tracker (32b).

## Test plan
- Reset with `RESET_PC`=0x100 and 1-cycle memory, `instr_ready`=1 → requests 0x100, 0x104, 0x108 on consecutive cycles; `Instr`/`PC` appear one cycle after each response; `PCPlus4`=0x104 for `PC`=0x100.
- `instr_ready`=0 for 10 cycles → at most 4 requests outstanding+buffered, `imem_req_valid` drops to 0, no entry lost; on release, PCs 0x100..0x10C drain in order.
- Handshake on `PC`=0x108 with `PCSrc`=1, `PCTarget`=0x203 → next `imem_addr`=0x200; responses for 0x10C/0x110 discarded; next valid `PC`=0x200.
- `PCSrc`=1 while `instr_valid`=0 or `instr_ready`=0 → no redirect; sequential PCs continue.
- `fetch_pc`=0xFFFF_FFF8 → requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; `PCPlus4` of 0xFFFF_FFFC is 0.
- Assert `rst` with 2 requests in flight; late responses arrive after release → ignored, `instr_valid`=0 until the fresh `RESET_PC` response; counters do not underflow.
